// File: rtl/cnn_pkg.sv
// Derived-size helpers shared by the CNN datapath blocks, so that the window
// buffer, MAC and pooling stages all elaborate identical constants.
package cnn_pkg;

  function automatic int fifo_size(input int ifm_size, input int kernal_size);
    return (kernal_size - 1) * ifm_size + kernal_size;
  endfunction

  function automatic int ifm_size_next(input int ifm_size, input int kernal_size,
                                       input int stride);
    return (ifm_size - kernal_size) / stride + 1;
  endfunction

  function automatic int cnt_bits(input int ifm_size);
    return (ifm_size > 1) ? $clog2(ifm_size) : 1;
  endfunction

endpackage

// File: rtl/window_position_tracker.sv
// Raster position, stride phase and output-map counters for the window buffer;
// flags each accepted pixel that completes a legal strided window.
module window_position_tracker
  import cnn_pkg::*;
#(
  parameter int IFM_SIZE      = 14,
  parameter int KERNAL_SIZE   = 5,
  parameter int STRIDE        = 1,
  parameter int IFM_SIZE_NEXT = ifm_size_next(IFM_SIZE, KERNAL_SIZE, STRIDE),
  parameter int CNT_BITS      = cnt_bits(IFM_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                frame_restart,
  output logic                window_valid,
  output logic [CNT_BITS-1:0] out_row,
  output logic [CNT_BITS-1:0] out_col,
  output logic                frame_done
);

  localparam logic [CNT_BITS-1:0] POS_LAST   = CNT_BITS'(IFM_SIZE - 1);
  localparam logic [CNT_BITS-1:0] K_LAST     = CNT_BITS'(KERNAL_SIZE - 1);
  localparam logic [CNT_BITS-1:0] PHASE_LAST = CNT_BITS'(STRIDE - 1);
  localparam logic [CNT_BITS-1:0] OUT_LAST   = CNT_BITS'(IFM_SIZE_NEXT - 1);

  logic [CNT_BITS-1:0] in_row, in_col, row_phase, col_phase, row_idx, col_idx;
  logic [CNT_BITS-1:0] cur_row, cur_col, cur_row_phase, cur_col_phase, cur_row_idx, cur_col_idx;
  logic [CNT_BITS-1:0] nxt_row, nxt_col, nxt_row_phase, nxt_col_phase, nxt_row_idx, nxt_col_idx;
  logic row_ok, col_ok, row_end, frame_end;

  // A restart makes the pixel in the same cycle position (0,0).
  always_comb begin
    cur_row       = frame_restart ? '0 : in_row;
    cur_col       = frame_restart ? '0 : in_col;
    cur_row_phase = frame_restart ? '0 : row_phase;
    cur_col_phase = frame_restart ? '0 : col_phase;
    cur_row_idx   = frame_restart ? '0 : row_idx;
    cur_col_idx   = frame_restart ? '0 : col_idx;
    row_ok        = (cur_row >= K_LAST) && (cur_row_phase == '0);
    col_ok        = (cur_col >= K_LAST) && (cur_col_phase == '0);
    row_end       = (cur_col == POS_LAST);
    frame_end     = row_end && (cur_row == POS_LAST);
  end

  always_comb begin
    nxt_row       = cur_row;
    nxt_col       = cur_col;
    nxt_row_phase = cur_row_phase;
    nxt_col_phase = cur_col_phase;
    nxt_row_idx   = cur_row_idx;
    nxt_col_idx   = cur_col_idx;
    if (in_valid) begin
      if (row_end) begin
        nxt_col       = '0;
        nxt_col_phase = '0;
        nxt_col_idx   = '0;
        if (frame_end) begin
          nxt_row       = '0;
          nxt_row_phase = '0;
          nxt_row_idx   = '0;
        end else begin
          nxt_row = cur_row + 1'b1;
          if (cur_row >= K_LAST)
            nxt_row_phase = (cur_row_phase == PHASE_LAST) ? '0 : cur_row_phase + 1'b1;
          if (row_ok)
            nxt_row_idx = (cur_row_idx == OUT_LAST) ? '0 : cur_row_idx + 1'b1;
        end
      end else begin
        nxt_col = cur_col + 1'b1;
        if (cur_col >= K_LAST)
          nxt_col_phase = (cur_col_phase == PHASE_LAST) ? '0 : cur_col_phase + 1'b1;
        if (col_ok)
          nxt_col_idx = (cur_col_idx == OUT_LAST) ? '0 : cur_col_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_row       <= '0;
      in_col       <= '0;
      row_phase    <= '0;
      col_phase    <= '0;
      row_idx      <= '0;
      col_idx      <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
    end else begin
      in_row       <= nxt_row;
      in_col       <= nxt_col;
      row_phase    <= nxt_row_phase;
      col_phase    <= nxt_col_phase;
      row_idx      <= nxt_row_idx;
      col_idx      <= nxt_col_idx;
      window_valid <= in_valid && row_ok && col_ok;
      frame_done   <= in_valid && frame_end;
      if (in_valid && row_ok && col_ok) begin
        out_row <= cur_row_idx;
        out_col <= cur_col_idx;
      end
    end
  end

endmodule

// File: rtl/sliding_window_buffer.sv
// Line-buffer window generator: shifts raster pixels through (K-1) rows plus K
// pixels and exposes the KxK window flat, with legality/position from the tracker.
module sliding_window_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int IFM_SIZE      = 14,
  parameter int KERNAL_SIZE   = 5,
  parameter int STRIDE        = 1,
  parameter int FIFO_SIZE     = fifo_size(IFM_SIZE, KERNAL_SIZE),
  parameter int IFM_SIZE_NEXT = ifm_size_next(IFM_SIZE, KERNAL_SIZE, STRIDE),
  parameter int CNT_BITS      = cnt_bits(IFM_SIZE)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_valid,
  input  logic [DATA_WIDTH-1:0]                         in_data,
  input  logic                                          frame_restart,
  output logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0] window_data,
  output logic                                          window_valid,
  output logic [CNT_BITS-1:0]                           out_row,
  output logic [CNT_BITS-1:0]                           out_col,
  output logic                                          frame_done
);

  logic [DATA_WIDTH-1:0] fifo [FIFO_SIZE];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int n = 0; n < FIFO_SIZE; n++) fifo[n] <= '0;
    end else if (in_valid) begin
      fifo[0] <= in_data;
      for (int n = 1; n < FIFO_SIZE; n++) fifo[n] <= fifo[n-1];
    end
  end

  // Element (i,j) sits (K-1-i) rows and (K-1-j) pixels behind the newest pixel.
  for (genvar i = 0; i < KERNAL_SIZE; i++) begin : g_row
    for (genvar j = 0; j < KERNAL_SIZE; j++) begin : g_col
      assign window_data[(i*KERNAL_SIZE+j)*DATA_WIDTH +: DATA_WIDTH] =
        fifo[(KERNAL_SIZE-1-i)*IFM_SIZE + (KERNAL_SIZE-1-j)];
    end
  end

  window_position_tracker #(
    .IFM_SIZE      (IFM_SIZE),
    .KERNAL_SIZE   (KERNAL_SIZE),
    .STRIDE        (STRIDE),
    .IFM_SIZE_NEXT (IFM_SIZE_NEXT),
    .CNT_BITS      (CNT_BITS)
  ) u_tracker (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .frame_restart (frame_restart),
    .window_valid  (window_valid),
    .out_row       (out_row),
    .out_col       (out_col),
    .frame_done    (frame_done)
  );

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Directed bench for sliding_window_buffer: 6x6 map, 3x3 kernel, stride 1 and 2
// instances driven by the same pixel stream (pixel value = r*6+c+1).
module tb_sliding_window_buffer;

  localparam int DW  = 8;
  localparam int IFM = 6;
  localparam int K   = 3;
  localparam int CB  = 3;
  localparam int WW  = K*K*DW;
  localparam logic [WW-1:0] FIRST_WIN = 72'h0F0E0D_090807_030201;

  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, frame_restart = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [WW-1:0] wd1, wd2;
  logic wv1, wv2, fd1, fd2;
  logic [CB-1:0] or1, oc1, or2, oc2;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  sliding_window_buffer #(.DATA_WIDTH(DW), .IFM_SIZE(IFM), .KERNAL_SIZE(K), .STRIDE(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .frame_restart(frame_restart), .window_data(wd1), .window_valid(wv1),
    .out_row(or1), .out_col(oc1), .frame_done(fd1));

  sliding_window_buffer #(.DATA_WIDTH(DW), .IFM_SIZE(IFM), .KERNAL_SIZE(K), .STRIDE(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .frame_restart(frame_restart), .window_data(wd2), .window_valid(wv2),
    .out_row(or2), .out_col(oc2), .frame_done(fd2));

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(r*IFM + c + 1);
  endfunction

  function automatic logic [WW-1:0] exp_window(input int r, input int c);
    logic [WW-1:0] w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*DW +: DW] = pix(r-K+1+i, c-K+1+j);
    return w;
  endfunction

  function automatic logic exp_legal(input int r, input int c, input int s);
    return (r >= K-1) && (c >= K-1) && ((r-K+1) % s == 0) && ((c-K+1) % s == 0);
  endfunction

  task automatic push(input logic [DW-1:0] d, input logic restart);
    in_valid = 1'b1; in_data = d; frame_restart = restart;
    @(posedge clk); #1;
    in_valid = 1'b0; frame_restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wd1 !== '0 || wd2 !== '0) begin n_fail++; $display("FAIL reset_window: got %h / %h want 0", wd1, wd2); end
    n_checks++; if ({wv1, fd1, wv2, fd2} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {wv1, fd1, wv2, fd2}); end
    n_checks++; if ({or1, oc1, or2, oc2} !== '0) begin n_fail++; $display("FAIL reset_pos: got %h want 0", {or1, oc1, or2, oc2}); end
    reset = 1'b1;
  endtask

  task automatic test_frame_stride();
    int p1 = 0, p2 = 0, r, c;
    logic [WW-1:0] first1 = '0;
    logic [23:0] top01 = '0;
    logic [2*CB-1:0] last1 = '0;
    for (int k = 0; k < IFM*IFM; k++) begin
      r = k / IFM; c = k % IFM;
      push(pix(r, c), 1'b0);
      n_checks++; if (wv1 !== exp_legal(r, c, 1)) begin n_fail++; $display("FAIL s1_valid beat %0d: got %b want %b", k, wv1, exp_legal(r, c, 1)); end
      n_checks++; if (wv2 !== exp_legal(r, c, 2)) begin n_fail++; $display("FAIL s2_valid beat %0d: got %b want %b", k, wv2, exp_legal(r, c, 2)); end
      n_checks++; if ({fd1, fd2} !== {2{k == IFM*IFM-1}}) begin n_fail++; $display("FAIL frame_done beat %0d: got %b", k, {fd1, fd2}); end
      if (wv1) begin p1++; if (p1 == 1) first1 = wd1; last1 = {or1, oc1}; end
      if (wv2) begin p2++; if ({or2, oc2} == {3'd0, 3'd1}) top01 = wd2[23:0]; end
      if (exp_legal(r, c, 1)) begin
        n_checks++; if (wd1 !== exp_window(r, c)) begin n_fail++; $display("FAIL s1_window (%0d,%0d): got %h want %h", r, c, wd1, exp_window(r, c)); end
        n_checks++; if ({or1, oc1} !== {CB'(r-2), CB'(c-2)}) begin n_fail++; $display("FAIL s1_pos (%0d,%0d): got %0d,%0d", r, c, or1, oc1); end
      end
      if (exp_legal(r, c, 2)) begin
        n_checks++; if (wd2 !== exp_window(r, c)) begin n_fail++; $display("FAIL s2_window (%0d,%0d): got %h want %h", r, c, wd2, exp_window(r, c)); end
        n_checks++; if ({or2, oc2} !== {CB'((r-2)/2), CB'((c-2)/2)}) begin n_fail++; $display("FAIL s2_pos (%0d,%0d): got %0d,%0d", r, c, or2, oc2); end
      end
    end
    n_checks++; if (p1 !== 16) begin n_fail++; $display("FAIL s1_count: got %0d want 16", p1); end
    n_checks++; if (first1 !== FIRST_WIN) begin n_fail++; $display("FAIL s1_first: got %h want %h", first1, FIRST_WIN); end
    n_checks++; if (last1 !== {3'd3, 3'd3}) begin n_fail++; $display("FAIL s1_last_pos: got %h want 1b", last1); end
    n_checks++; if (p2 !== 4) begin n_fail++; $display("FAIL s2_count: got %0d want 4", p2); end
    n_checks++; if (top01 !== 24'h050403) begin n_fail++; $display("FAIL s2_top_row_01: got %h want 050403", top01); end
  endtask

  task automatic test_gaps();
    int p1 = 0, p2 = 0, r, c;
    for (int k = 0; k < IFM*IFM; k++) begin
      r = k / IFM; c = k % IFM;
      push(pix(r, c), 1'b0);
      n_checks++; if ({wv1, wv2} !== {exp_legal(r, c, 1), exp_legal(r, c, 2)}) begin n_fail++; $display("FAIL gap_valid beat %0d: got %b", k, {wv1, wv2}); end
      if (wv1) p1++;
      if (wv2) p2++;
      if (exp_legal(r, c, 1)) begin
        n_checks++; if (wd1 !== exp_window(r, c) || {or1, oc1} !== {CB'(r-2), CB'(c-2)}) begin n_fail++; $display("FAIL gap_window (%0d,%0d): got %h pos %0d,%0d", r, c, wd1, or1, oc1); end
      end
      for (int g = 0; g < (k % 3) + 1; g++) begin
        @(posedge clk); #1;
        n_checks++; if ({wv1, wv2, fd1, fd2} !== 4'b0) begin n_fail++; $display("FAIL gap_idle beat %0d: got %b want 0000", k, {wv1, wv2, fd1, fd2}); end
      end
    end
    n_checks++; if (p1 !== 16 || p2 !== 4) begin n_fail++; $display("FAIL gap_count: got %0d/%0d want 16/4", p1, p2); end
  endtask

  task automatic test_two_frames();
    int p1 = 0, r, c;
    logic [WW-1:0] first2 = '0;
    for (int k = 0; k < 2*IFM*IFM; k++) begin
      r = (k % (IFM*IFM)) / IFM; c = k % IFM;
      push(pix(r, c), 1'b0);
      n_checks++; if (wv1 !== exp_legal(r, c, 1)) begin n_fail++; $display("FAIL bb_valid beat %0d: got %b want %b", k, wv1, exp_legal(r, c, 1)); end
      n_checks++; if (fd1 !== (k % (IFM*IFM) == IFM*IFM-1)) begin n_fail++; $display("FAIL bb_frame_done beat %0d: got %b", k, fd1); end
      if (wv1) begin p1++; if (p1 == 17) first2 = wd1; end
      if (exp_legal(r, c, 1)) begin
        n_checks++; if (wd1 !== exp_window(r, c)) begin n_fail++; $display("FAIL bb_window beat %0d: got %h want %h", k, wd1, exp_window(r, c)); end
      end
    end
    n_checks++; if (p1 !== 32) begin n_fail++; $display("FAIL bb_count: got %0d want 32", p1); end
    n_checks++; if (first2 !== FIRST_WIN) begin n_fail++; $display("FAIL bb_first2: got %h want %h", first2, FIRST_WIN); end
  endtask

  task automatic test_mid_reset();
    int first_beat = -1, r, c;
    for (int k = 0; k < 20; k++) push(pix(k / IFM, k % IFM), 1'b0);
    reset = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (wd1 !== '0 || wd2 !== '0) begin n_fail++; $display("FAIL rst_window: got %h / %h want 0", wd1, wd2); end
    n_checks++; if ({wv1, fd1, wv2, fd2, or1, oc1, or2, oc2} !== '0) begin n_fail++; $display("FAIL rst_outputs: got %h want 0", {wv1, fd1, wv2, fd2, or1, oc1, or2, oc2}); end
    reset = 1'b1;
    for (int k = 0; k < IFM*IFM; k++) begin
      r = k / IFM; c = k % IFM;
      push(pix(r, c), 1'b0);
      n_checks++; if (wv1 !== exp_legal(r, c, 1)) begin n_fail++; $display("FAIL rst_valid beat %0d: got %b want %b", k, wv1, exp_legal(r, c, 1)); end
      if (wv1 && first_beat < 0) begin
        first_beat = k;
        n_checks++; if (wd1 !== FIRST_WIN || {or1, oc1} !== '0) begin n_fail++; $display("FAIL rst_first_window: got %h pos %0d,%0d", wd1, or1, oc1); end
      end
    end
    n_checks++; if (first_beat !== 14) begin n_fail++; $display("FAIL rst_first_beat: got %0d want 14", first_beat); end
  endtask

  task automatic test_frame_restart();
    int first_beat = -1, p1 = 0, r, c;
    for (int k = 0; k < 9; k++) begin
      push(pix(k / IFM, k % IFM), 1'b0);
      n_checks++; if (wv1 !== 1'b0) begin n_fail++; $display("FAIL fr_pre_valid beat %0d: got %b want 0", k, wv1); end
    end
    for (int k = 0; k < IFM*IFM; k++) begin
      r = k / IFM; c = k % IFM;
      push(pix(r, c), k == 0);
      n_checks++; if ({wv1, wv2} !== {exp_legal(r, c, 1), exp_legal(r, c, 2)}) begin n_fail++; $display("FAIL fr_valid beat %0d: got %b", k, {wv1, wv2}); end
      if (wv1) p1++;
      if (wv1 && first_beat < 0) begin
        first_beat = k;
        n_checks++; if (wd1 !== FIRST_WIN || {or1, oc1} !== '0) begin n_fail++; $display("FAIL fr_first_window: got %h pos %0d,%0d", wd1, or1, oc1); end
      end
    end
    n_checks++; if (first_beat !== 14) begin n_fail++; $display("FAIL fr_first_beat: got %0d want 14", first_beat); end
    n_checks++; if (p1 !== 16) begin n_fail++; $display("FAIL fr_count: got %0d want 16", p1); end
  endtask

  initial begin
    test_reset();
    test_frame_stride();
    test_gaps();
    test_two_frames();
    test_mid_reset();
    test_frame_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
